// File: rtl/seq_mult.sv
// Iterative Booth multiplier with a start/done handshake: full 2N-bit product, signed or unsigned per operation.
// Optional macro SEQ_MULT_RADIX4_EN selects radix-4 recoding ((N+2)/2 steps) instead of radix-2 (N+1 steps).
module seq_mult #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

`ifdef SEQ_MULT_RADIX4_EN
  localparam int unsigned MW    = N + 2;
  localparam int unsigned AW    = N + 4;
  localparam int unsigned STEPS = (N + 2) / 2;
  localparam int unsigned SH    = 2;
`else
  localparam int unsigned MW    = N + 1;
  localparam int unsigned AW    = N + 2;
  localparam int unsigned STEPS = N + 1;
  localparam int unsigned SH    = 1;
`endif
  localparam int unsigned CW = $clog2(STEPS + 1);
  localparam int unsigned TW = AW + MW + 1;

  if (N < 2) begin : g_bad_width
    $error("seq_mult: N must be at least 2");
  end
`ifdef SEQ_MULT_RADIX4_EN
  if ((N % 2) != 0) begin : g_bad_parity
    $error("seq_mult: radix-4 recoding requires an even N");
  end
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                 state_q, state_n;
  logic [AW-1:0]          acc_q, acc_n;
  logic [AW-1:0]          mcand_q, mcand_n;
  logic [MW-1:0]          mq_q, mq_n;
  logic                   qm1_q, qm1_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic                   busy_n, done_n;
  logic [2*N-1:0]         product_n;
  logic [AW-1:0]          sum;
  logic signed [TW-1:0]   sh;

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    mcand_n   = mcand_q;
    mq_n      = mq_q;
    qm1_n     = qm1_q;
    cnt_n     = cnt_q;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    product_n = product;
    sum       = acc_q;
    sh        = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_BUSY;
          busy_n  = 1'b1;
          acc_n   = '0;
          mcand_n = {{(AW-N){signed_mode & a[N-1]}}, a};
          mq_n    = {{(MW-N){signed_mode & b[N-1]}}, b};
          qm1_n   = 1'b0;
          cnt_n   = CW'(STEPS);
        end else begin
          state_n = S_IDLE;
        end
      end

      S_BUSY: begin
`ifdef SEQ_MULT_RADIX4_EN
        case ({mq_q[1:0], qm1_q})
          3'b001, 3'b010: sum = acc_q + mcand_q;
          3'b011:         sum = acc_q + (mcand_q << 1);
          3'b100:         sum = acc_q - (mcand_q << 1);
          3'b101, 3'b110: sum = acc_q - mcand_q;
          default:        sum = acc_q;
        endcase
`else
        case ({mq_q[0], qm1_q})
          2'b10:   sum = acc_q - mcand_q;
          2'b01:   sum = acc_q + mcand_q;
          default: sum = acc_q;
        endcase
`endif
        // Arithmetic shift of the whole {acc, multiplier, q(-1)} register
        sh    = $signed({sum, mq_q, qm1_q}) >>> SH;
        acc_n = sh[TW-1 -: AW];
        mq_n  = sh[MW:1];
        qm1_n = sh[0];
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n   = S_DONE;
          done_n    = 1'b1;
          product_n = sh[2*N:1];
        end else begin
          busy_n = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      mcand_q <= mcand_n;
      mq_q    <= mq_n;
      qm1_q   <= qm1_n;
      cnt_q   <= cnt_n;
      busy    <= busy_n;
      done    <= done_n;
      product <= product_n;
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (N=8): directed vector table, handshake/reset sequences and random back-to-back ops.
module tb_seq_mult;
  localparam int N = 8;
`ifdef SEQ_MULT_RADIX4_EN
  localparam int ITERS = (N + 2) / 2;
`else
  localparam int ITERS = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [N-1:0] a, b;
  logic         busy, done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer multiply of sign- or zero-extended operands, truncated to 2N bits
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic sm);
    longint sx, sy;
    sx = sm ? longint'($signed(x)) : longint'(x);
    sy = sm ? longint'($signed(y)) : longint'(y);
    return 16'(sx * sy);
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic sm,
                       input logic [15:0] exp, input string nm);
    int n;
    a = x; b = y; signed_mode = sm; start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, " busy after accept"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 64) begin
      tick();
      n++;
    end
    check({nm, " latency"}, 64'(n), 64'(ITERS));
    check({nm, " product"}, 64'(product), 64'(exp));
    tick();
    check({nm, " done drops"}, 64'(done), 64'd0);
    check({nm, " product holds"}, 64'(product), 64'(exp));
  endtask

  initial begin
    vec_t vecs[12];
    int n, nd, last_t;
    int dts[$];
    logic [15:0] dprod, exp;
    logic [7:0] ca, cb, na, nb;
    logic csm, nsm;

    vecs[0]  = '{8'd37, 8'd25, 1'b1, 16'd925};
    vecs[1]  = '{8'hFB, 8'h02, 1'b1, 16'hFFF6};
    vecs[2]  = '{8'h02, 8'hFB, 1'b1, 16'hFFF6};
    vecs[3]  = '{8'hFE, 8'hFB, 1'b1, 16'h000A};
    vecs[4]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[7]  = '{8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[8]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[9]  = '{8'h7F, 8'h80, 1'b0, 16'h3F80};
    vecs[10] = '{8'h00, 8'h5A, 1'b1, 16'h0000};
    vecs[11] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", 64'(product), 64'd0);

    // First operation watched cycle by cycle
    a = 8'd37; b = 8'd25; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < ITERS; i++) begin
      check($sformatf("37x25 busy c%0d", i), 64'(busy), 64'd1);
      check($sformatf("37x25 done c%0d", i), 64'(done), 64'd0);
      tick();
    end
    check("37x25 done pulse", 64'(done), 64'd1);
    check("37x25 busy at done", 64'(busy), 64'd0);
    check("37x25 product", 64'(product), 64'd925);
    tick();
    check("37x25 done low", 64'(done), 64'd0);
    check("37x25 hold", 64'(product), 64'd925);

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, $sformatf("vec%0d", i));

    // Start and operand changes while BUSY are ignored
    a = 8'd7; b = 8'd3; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'h55; b = 8'h66; signed_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0; dprod = '0;
    for (int i = 0; i < 3 * ITERS; i++) begin
      if (done) begin nd++; dprod = product; end
      tick();
    end
    check("busy-start done count", 64'(nd), 64'd1);
    check("busy-start product", 64'(dprod), 64'd21);
    check("busy-start idle after", 64'(busy), 64'd0);

    // Continuous start: one result per ITERS+1 cycles
    a = 8'd3; b = 8'd5; signed_mode = 1'b0; start = 1'b1;
    tick();
    for (int t = 1; t <= 4 * (ITERS + 1) + 1; t++) begin
      if (done) begin
        dts.push_back(t - 1);
        check($sformatf("b2b product t%0d", t - 1), 64'(product), 64'd15);
      end
      tick();
    end
    start = 1'b0;
    check("b2b done count", 64'(dts.size() >= 3), 64'd1);
    if (dts.size() > 0) check("b2b first done", 64'(dts[0]), 64'(ITERS));
    for (int i = 1; i < dts.size(); i++)
      check($sformatf("b2b period %0d", i), 64'(dts[i] - dts[i-1]), 64'(ITERS + 1));
    for (int i = 0; i < ITERS + 3; i++) tick();

    // Reset during BUSY aborts without a done pulse
    a = 8'd9; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort product", 64'(product), 64'd0);
    nd = 0;
    for (int i = 0; i < ITERS + 3; i++) begin
      if (done) nd++;
      tick();
    end
    check("abort no done", 64'(nd), 64'd0);
    check("abort product stays", 64'(product), 64'd0);
    do_op(8'd6, 8'd7, 1'b0, 16'd42, "after abort");

    // 200 random operations, back-to-back via start in DONE
    ca = 8'($urandom); cb = 8'($urandom); csm = 1'($urandom);
    a = ca; b = cb; signed_mode = csm; start = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) begin
      exp = model(ca, cb, csm);
      na = 8'($urandom); nb = 8'($urandom); nsm = 1'($urandom);
      a = na; b = nb; signed_mode = nsm;
      if (i == 199) start = 1'b0;
      n = 0;
      while (!done && n < 64) begin
        tick();
        n++;
      end
      check($sformatf("rnd%0d latency", i), 64'(n), 64'(ITERS));
      check($sformatf("rnd%0d a=%0h b=%0h sm=%0d product", i, ca, cb, csm), 64'(product), 64'(exp));
      ca = na; cb = nb; csm = nsm;
      tick();
    end
    check("rnd end done low", 64'(done), 64'd0);
    check("rnd end idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised, iterative, multi-cycle multiplier. Successor to the combinational signed multiplier.
- Computes a full 2N-bit product of two N-bit operands, signed or unsigned, selected per operation.
- Uses radix-2 Booth recoding with a start/done handshake.
- Trades latency for area. Sits between a register-file/controller and any datapath that can tolerate multi-cycle multiply.

Parameters:
- N, 8, operand width in bits; N >= 2; product width is 2N.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- signed_mode  input  1  1 = both operands two's complement, 0 = both unsigned; captured with operands
- a  input  N  multiplicand
- b  input  N  multiplier
- busy  output  1  high while iterating (BUSY state)
- done  output  1  one-cycle pulse, product valid and newly updated
- product  output  2N  result register; holds last result until next completion

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs. State -> IDLE, busy=0, done=0, product=0, internal accumulators and counter cleared. Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States:
  - IDLE: waits for start.
  - BUSY: performs iterations.
  - DONE: single cycle, then returns to IDLE unless a new start is accepted.
- Accept: start=1 at a rising edge while in IDLE or DONE.
  - Captures a, b and signed_mode.
  - Extends each operand to N+1 bits: sign-extended if signed_mode=1, zero-extended otherwise.
  - Clears the accumulator and loads counter = N+1. Next state is BUSY.
- BUSY, each edge: one radix-2 Booth step on the (N+1)-bit multiplier with an implicit bit q(-1)=0 at load.
  - 10 -> subtract the multiplicand.
  - 01 -> add the multiplicand.
  - 00/11 -> no op.
  - Then arithmetic right shift of the {acc, multiplier, q(-1)} register. Counter decrements.
- The step at which counter reaches 0 writes product = low 2N bits of the (2N+2)-bit result. Next state is DONE.
- Latency: start sampled at edge k; done=1 and product updated during the cycle following edge k+N+1 (N=8: 9 cycles). busy=1 exactly for cycles after edges k..k+N.
- Handshake:
  - start while BUSY is ignored; the captured operands are unaffected.
  - a/b/signed_mode changes after accept have no effect.
  - start=1 in the DONE cycle is accepted, giving back-to-back operations at one result per N+2 cycles. done still pulses for exactly one cycle.
- Arithmetic: results are exact for all 2^(2N) operand pairs in both modes. Corner cases:
  - Signed most-negative times most-negative (N=8: -128*-128 = 16384) is exact.
  - Unsigned all-ones squared (N=8: 255*255 = 65025) is exact.
- No overflow is possible; no output flags beyond busy/done.

Optional Feature:
- Macro SEQ_MULT_RADIX4_EN.
- Defined:
  - Radix-4 Booth recoding; the operand is extended to N+2 bits. Requires N even; an elaboration-time error is raised otherwise.
  - Per step, examines 3 bits and adds one of {0, ±M, ±2M}, then shifts by 2.
  - Iteration count is (N+2)/2 (N=8: 5). Done is at edge k+(N+2)/2, one cycle later.
  - Back-to-back throughput becomes one result per (N+2)/2+1 cycles.
  - Handshake, reset and results are otherwise identical.
- Undefined: radix-2 behaviour as specified above.

Test Plan:
- Reset, then signed_mode=1, a=37, b=25, start pulse -> busy for 9 cycles, then done=1 for one cycle with product=16'd925. product holds 925 afterwards; done returns to 0.
- Signed sign cases -> product 0xFFF6, 0xFFF6, 0x000A, and 0x4000 respectively:
  - a=0xFB, b=0x02
  - a=0x02, b=0xFB
  - a=0xFE, b=0xFB
  - a=0x80, b=0x80
- Mode select with a=0xFF, b=0xFF -> signed_mode=1 gives 0x0001; signed_mode=0 gives 0xFE01. Also unsigned a=0x80, b=0x02 -> 0x0100.
- Handshake and reset:
  - After accept of 7*3, change a/b and pulse start during BUSY -> single done with product=21.
  - Start asserted continuously -> done every 10 cycles, one pulse each.
  - rst at cycle 4 of BUSY -> busy=0, product=0, no done; a fresh start then completes normally.
- Random: 200 operations with random a, b and signed_mode, back-to-back via start in DONE. Each product checks against a 2N-bit reference multiply using sign- or zero-extended operands; any mismatch is displayed with operands and expected value.
- With SEQ_MULT_RADIX4_EN defined, rerun all scenarios -> identical results, done after 5 cycles for N=8.
